// File: rtl/im_access_ctrl.sv
// Front-end controller for the single-port instruction memory: BOOT-phase loader access,
// RUN-phase round-robin sharing between loader writes and fetch reads, pc validation.
module im_access_ctrl #(
    parameter int DataSize  = 32,
    parameter int AddrWidth = 10,
    parameter int PcWidth   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 boot_done_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [AddrWidth-1:0] ld_addr_i,
    input  logic [DataSize-1:0]  ld_data_i,
    input  logic                 fetch_valid_i,
    output logic                 fetch_ready_o,
    input  logic [PcWidth-1:0]   fetch_pc_i,
    output logic                 fetch_rvalid_o,
    output logic [DataSize-1:0]  fetch_rdata_o,
    output logic                 fetch_err_o,
    output logic [AddrWidth:0]   ld_count_o,
    output logic                 running_o,
    output logic [AddrWidth-1:0] im_addr_o,
    output logic                 im_enable_mem_o,
    output logic                 im_enable_fetch_o,
    output logic                 im_enable_write_o,
    output logic [DataSize-1:0]  im_wdata_o,
    input  logic [DataSize-1:0]  im_rdata_i
);

    typedef enum logic {
        Boot,
        Run
    } state_e;

    localparam logic [AddrWidth:0] CountMax = {1'b1, {AddrWidth{1'b0}}};

    state_e                state_q, state_d;
    logic                  lastFetch_q, lastFetch_d;
    logic [AddrWidth:0]    ldCount_q, ldCount_d;
    logic [AddrWidth-1:0]  addr_q;
    logic [DataSize-1:0]   wdata_q;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    logic                  ldAcc, fetchAcc, fetchMem, pcOk;
    logic [AddrWidth-1:0]  pcWord;

    assign pcOk   = (fetch_pc_i[1:0] == 2'b00) && (fetch_pc_i[PcWidth-1:AddrWidth+2] == '0);
    assign pcWord = fetch_pc_i[AddrWidth+1:2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Boot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == Boot && boot_done_i) begin
            state_d = Run;
        end
    end

    // Grants depend only on state, valids and the round-robin pointer; reset blocks both.
    always_comb begin
        ld_ready_o    = 1'b0;
        fetch_ready_o = 1'b0;
        if (rst_ni) begin
            case (state_q)
                Boot: ld_ready_o = 1'b1;
                Run: begin
                    ld_ready_o    = ld_valid_i && (!fetch_valid_i || lastFetch_q);
                    fetch_ready_o = fetch_valid_i && (!ld_valid_i || !lastFetch_q);
                end
                default: ;
            endcase
        end
    end

    assign ldAcc    = ld_valid_i && ld_ready_o;
    assign fetchAcc = fetch_valid_i && fetch_ready_o;
    assign fetchMem = fetchAcc && pcOk;

    always_comb begin
        im_enable_mem_o   = ldAcc || fetchMem;
        im_enable_write_o = ldAcc;
        im_enable_fetch_o = fetchMem;
        im_addr_o         = addr_q;
        im_wdata_o        = wdata_q;
        if (ldAcc) begin
            im_addr_o  = ld_addr_i;
            im_wdata_o = ld_data_i;
        end else if (fetchMem) begin
            im_addr_o = pcWord;
        end
    end

    always_comb begin
        lastFetch_d = lastFetch_q;
        if (ldAcc) begin
            lastFetch_d = 1'b0;
        end else if (fetchAcc) begin
            lastFetch_d = 1'b1;
        end
        ldCount_d = ldCount_q;
        if (ldAcc && ldCount_q != CountMax) begin
            ldCount_d = ldCount_q + 1'b1;
        end
        rvalid_d = fetchAcc;
        err_d    = fetchAcc && !pcOk;
    end

    // Address/wdata registers make the IM bus hold its last value when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lastFetch_q <= 1'b0;
            ldCount_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            lastFetch_q <= lastFetch_d;
            ldCount_q   <= ldCount_d;
            addr_q      <= im_addr_o;
            wdata_q     <= im_wdata_o;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
        end
    end

    assign fetch_rvalid_o = rvalid_q;
    assign fetch_err_o    = err_q;
    assign fetch_rdata_o  = (rvalid_q && !err_q) ? im_rdata_i : '0;
    assign ld_count_o     = ldCount_q;
    assign running_o      = (state_q == Run);

endmodule

// File: tb/tb_im_access_ctrl.sv
// Bench for im_access_ctrl: table of per-cycle vectors plus a response scoreboard,
// a behavioural 1024x32 IM, and hand-written reset and count-saturation sequences.
module tb_im_access_ctrl;

    typedef struct {
        logic        bootDone;
        logic        ldValid;
        logic [9:0]  ldAddr;
        logic [31:0] ldData;
        logic        fetchValid;
        logic [31:0] fetchPc;
        logic        expLdReady;
        logic        expFetchReady;
        logic        expRunning;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bootDone, ldValid, ldReady, fetchValid, fetchReady;
    logic [9:0]  ldAddr;
    logic [31:0] ldData, fetchPc;
    logic        fetchRvalid, fetchErr, running;
    logic [31:0] fetchRdata;
    logic [10:0] ldCount;
    logic [9:0]  imAddr;
    logic        imEnMem, imEnFetch, imEnWrite;
    logic [31:0] imWdata;
    logic [31:0] imRdata = '0;

    logic [31:0] imMem  [1024];
    logic [31:0] refMem [1024];

    int          checks = 0;
    int          failures = 0;
    resp_t       sbQueue[$];
    vec_t        vecs[18];
    int          expCount = 0;
    logic [9:0]  lastAddr = '0;
    logic [31:0] lastWdata = '0;

    im_access_ctrl dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .boot_done_i       (bootDone),
        .ld_valid_i        (ldValid),
        .ld_ready_o        (ldReady),
        .ld_addr_i         (ldAddr),
        .ld_data_i         (ldData),
        .fetch_valid_i     (fetchValid),
        .fetch_ready_o     (fetchReady),
        .fetch_pc_i        (fetchPc),
        .fetch_rvalid_o    (fetchRvalid),
        .fetch_rdata_o     (fetchRdata),
        .fetch_err_o       (fetchErr),
        .ld_count_o        (ldCount),
        .running_o         (running),
        .im_addr_o         (imAddr),
        .im_enable_mem_o   (imEnMem),
        .im_enable_fetch_o (imEnFetch),
        .im_enable_write_o (imEnWrite),
        .im_wdata_o        (imWdata),
        .im_rdata_i        (imRdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imEnMem && imEnWrite) imMem[imAddr] <= imWdata;
        if (imEnMem && imEnFetch) imRdata <= imMem[imAddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bootDone   = v.bootDone;
        ldValid    = v.ldValid;
        ldAddr     = v.ldAddr;
        ldData     = v.ldData;
        fetchValid = v.fetchValid;
        fetchPc    = v.fetchPc;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic        ldAcc, fAcc, pcOk, fMem;
        logic [9:0]  expAddr;
        logic [31:0] expWdata;
        resp_t       e;
        string       tag;
        tag = $sformatf("v%0d", idx);
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            check({tag, ".rvalid"}, 64'(fetchRvalid), 64'd1);
            check({tag, ".err"}, 64'(fetchErr), 64'(e.err));
            check({tag, ".rdata"}, 64'(fetchRdata), 64'(e.data));
        end else begin
            check({tag, ".rvalid_idle"}, 64'(fetchRvalid), 64'd0);
        end
        ldAcc    = v.ldValid && v.expLdReady;
        fAcc     = v.fetchValid && v.expFetchReady;
        pcOk     = (v.fetchPc[1:0] == 2'b00) && (v.fetchPc[31:12] == 20'd0);
        fMem     = fAcc && pcOk;
        expAddr  = ldAcc ? v.ldAddr : (fMem ? v.fetchPc[11:2] : lastAddr);
        expWdata = ldAcc ? v.ldData : lastWdata;
        check({tag, ".ld_ready"}, 64'(ldReady), 64'(v.expLdReady));
        check({tag, ".fetch_ready"}, 64'(fetchReady), 64'(v.expFetchReady));
        check({tag, ".running"}, 64'(running), 64'(v.expRunning));
        check({tag, ".ld_count"}, 64'(ldCount), 64'(expCount));
        check({tag, ".en_mem"}, 64'(imEnMem), 64'(ldAcc || fMem));
        check({tag, ".en_write"}, 64'(imEnWrite), 64'(ldAcc));
        check({tag, ".en_fetch"}, 64'(imEnFetch), 64'(fMem));
        check({tag, ".im_addr"}, 64'(imAddr), 64'(expAddr));
        check({tag, ".im_wdata"}, 64'(imWdata), 64'(expWdata));
        if (ldAcc) begin
            refMem[v.ldAddr] = v.ldData;
            if (expCount < 1024) expCount++;
        end
        lastAddr  = expAddr;
        lastWdata = expWdata;
        if (fAcc) begin
            e.err  = !pcOk;
            e.data = pcOk ? refMem[v.fetchPc[11:2]] : 32'd0;
            sbQueue.push_back(e);
        end
    endtask

    initial begin
        // bootDone, ldValid, ldAddr, ldData, fetchValid, fetchPc, expLd, expFetch, expRun
        vecs[0]  = '{1'b0, 1'b1, 10'h080, 32'h11111111, 1'b1, 32'h0,    1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 10'h081, 32'h22222222, 1'b1, 32'h0,    1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h0,    1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 10'h082, 32'h33333333, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h200,  1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h204,  1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 10'h010, 32'hAAAA0001, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 10'h011, 32'hAAAA0002, 1'b1, 32'h40,   1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 10'h011, 32'hAAAA0002, 1'b1, 32'h44,   1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 10'h012, 32'hAAAA0003, 1'b1, 32'h44,   1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 10'h012, 32'hAAAA0003, 1'b1, 32'h48,   1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h202,  1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h1000, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h14,   1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h208,  1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        bootDone = 1'b0; ldValid = 1'b0; ldAddr = '0; ldData = '0;
        fetchValid = 1'b1; fetchPc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ld_ready", 64'(ldReady), 64'd0);
        check("rst.fetch_ready", 64'(fetchReady), 64'd0);
        check("rst.running", 64'(running), 64'd0);
        check("rst.ld_count", 64'(ldCount), 64'd0);
        check("rst.rvalid", 64'(fetchRvalid), 64'd0);
        check("rst.im_bus", 64'({imEnMem, imEnFetch, imEnWrite, imAddr}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
            @(posedge clk); #1;
        end

        // Reset in the middle of a back-to-back fetch stream.
        bootDone = 1'b0; ldValid = 1'b0; fetchValid = 1'b1; fetchPc = 32'h200;
        @(negedge clk);
        check("stream.fetch_ready", 64'(fetchReady), 64'd1);
        @(posedge clk); #1;
        fetchPc = 32'h204;
        #1;
        check("stream.rvalid", 64'(fetchRvalid), 64'd1);
        check("stream.rdata", 64'(fetchRdata), 64'h11111111);
        rst_n = 1'b0;
        #1;
        check("arst.rvalid", 64'(fetchRvalid), 64'd0);
        check("arst.rdata", 64'(fetchRdata), 64'd0);
        check("arst.err", 64'(fetchErr), 64'd0);
        check("arst.readies", 64'({ldReady, fetchReady}), 64'd0);
        check("arst.running", 64'(running), 64'd0);
        check("arst.im_en", 64'({imEnMem, imEnFetch, imEnWrite}), 64'd0);
        check("arst.im_addr", 64'(imAddr), 64'd0);
        check("arst.im_wdata", 64'(imWdata), 64'd0);
        sbQueue.delete();
        expCount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post.fetch_ready", 64'(fetchReady), 64'd0);
        check("post.ld_ready", 64'(ldReady), 64'd1);
        check("post.ld_count", 64'(ldCount), 64'd0);
        check("post.running", 64'(running), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post.no_resp", 64'(fetchRvalid), 64'd0);

        // Write-count saturation at 2**AddrWidth.
        @(posedge clk); #1;
        fetchValid = 1'b0;
        for (int i = 0; i < 1025; i++) begin
            ldValid = 1'b1;
            ldAddr  = i[9:0];
            ldData  = i;
            @(posedge clk); #1;
            if (i == 1022) check("sat.ld_count_1023", 64'(ldCount), 64'd1023);
        end
        ldValid = 1'b0;
        check("sat.ld_count_max", 64'(ldCount), 64'd1024);
        @(posedge clk); #1;
        check("sat.ld_count_hold", 64'(ldCount), 64'd1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/im_access_ctrl.md
Name: im_access_ctrl

Overview:
- Front-end controller for the single-port instruction memory (1024 x 32, one-cycle registered read).
- Shares the memory between two requesters: the program loader (writes) and the CPU fetch stage (reads).
- Provides a BOOT phase in which only the loader may access the memory, and a RUN phase with round-robin arbitration.
- Converts fetch byte addresses to word indices and reports address errors. Sits between the fetch stage/loader and the IM.

Parameters:
- DataSize, 32, data word width
- AddrWidth, 10, IM word-address width (MemSize = 2**AddrWidth)
- PcWidth, 32, fetch byte-address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- boot_done  in  1  one-cycle pulse: leave BOOT, enter RUN
- ld_valid  in  1  loader write request
- ld_ready  out  1  loader request accepted this cycle
- ld_addr  in  AddrWidth  loader word address
- ld_data  in  DataSize  loader write data
- fetch_valid  in  1  CPU fetch request
- fetch_ready  out  1  fetch request accepted this cycle
- fetch_pc  in  PcWidth  fetch byte address
- fetch_rvalid  out  1  fetch response valid
- fetch_rdata  out  DataSize  fetched instruction
- fetch_err  out  1  response flags a misaligned or out-of-range pc
- ld_count  out  AddrWidth+1  accepted writes since reset, saturating at 2**AddrWidth
- running  out  1  high in RUN
- im_addr  out  AddrWidth  to IM address
- im_enable_mem  out  1  to IM enable_mem
- im_enable_fetch  out  1  to IM enable_fetch
- im_enable_write  out  1  to IM enable_write
- im_wdata  out  DataSize  to IM write data
- im_rdata  in  DataSize  from IM read data

Behaviour:
- Reset (rst=0, asynchronous):
  - State = BOOT; round-robin pointer = "loader last".
  - ld_count = 0; fetch_rvalid = 0; fetch_err = 0; fetch_rdata = 0; running = 0.
  - All im_* outputs = 0; ld_ready = 0; fetch_ready = 0.
  - A request in flight when reset asserts is dropped, with no response.
- Handshake: a request is accepted in a cycle where valid & ready. ready is combinational from state and valid inputs, not from the other requester's ready. IM-side outputs are combinational for the accepted request, so the IM acts at the end of the same cycle.
- BOOT:
  - ld_ready = 1 whenever not in reset; fetch_ready = 0.
  - boot_done moves the state to RUN at the next edge.
  - A loader request accepted in the same cycle as boot_done still completes.
- RUN (terminal until reset):
  - Only one requester valid: that requester gets ready = 1.
  - Both valid: grant the requester that did not win the last grant; the pointer updates on every grant.
  - After reset the first conflict goes to fetch.
  - boot_done is ignored in RUN.
- Accepted write:
  - im_enable_mem = 1, im_enable_write = 1, im_enable_fetch = 0, im_addr = ld_addr, im_wdata = ld_data.
  - ld_count increments at the edge, saturating.
- Accepted fetch with a valid pc (pc[1:0] == 0 and pc[PcWidth-1:AddrWidth+2] == 0):
  - im_enable_mem = 1, im_enable_fetch = 1, im_addr = pc[AddrWidth+1:2].
  - In the next cycle: fetch_rvalid = 1, fetch_rdata = im_rdata, fetch_err = 0.
  - The rdata capture/forward is registered so the value is stable for the whole response cycle.
- Accepted fetch with an invalid pc:
  - No IM access (all im_enable_* = 0).
  - Next cycle: fetch_rvalid = 1, fetch_err = 1, fetch_rdata = 0.
- Timing:
  - Fetch latency is exactly 1 cycle; back-to-back fetches give one response per cycle.
  - The response has no backpressure; the fetch stage must accept it.
  - fetch_rvalid is low in any cycle not following an accepted fetch.
- Read-after-write: a write accepted in cycle N followed by a fetch of the same word in cycle N+1 returns the new data.
- im_enable_fetch and im_enable_write are never both high. With no accepted request, all im_enable_* = 0 and im_addr/im_wdata hold their last values.

Test Plan:
- Reset then BOOT: write 0x11111111 to word 0x80, 0x22222222 to 0x81 with fetch_valid=1 throughout -> ld_ready=1 each cycle, fetch_ready=0, ld_count=2, no fetch_rvalid.
- boot_done pulse, then fetch pc 0x200 and 0x204 back-to-back -> fetch_rvalid in the following two cycles with rdata 0x11111111, 0x22222222, err=0; running=1.
- RUN, both requesters valid for 4 cycles -> grants in order fetch, loader, fetch, loader; enable_fetch and enable_write never both high.
- Fetch pc 0x202 and pc 0x1000 -> fetch_err=1, rdata=0 one cycle later; im_enable_mem stays 0 in the request cycles.
- Write 0xDEADBEEF to word 5 in cycle N, fetch pc 0x14 in N+1 -> rdata 0xDEADBEEF.
- Assert rst mid back-to-back fetch stream -> all outputs 0 immediately; after release the state is BOOT (fetch_ready=0) and ld_count=0.
